regfile_wr_arbiter: RTL and testbench
=====================================

REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 4: B-side pending write queue entries.
REQ-002 SHALL have parameter STARVE_LIMIT, default 8: cycles a live queue head may lose arbitration before stall_req asserts.
REQ-003 SHALL have: clk  in  1  single clock, all state on rising edge.
REQ-004 SHALL have: rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have: a_valid  in  1  pipeline writeback request; no backpressure, always accepted.
REQ-006 SHALL have: a_addr  in  5  / a_data  in  32  pipeline writeback destination and value.
REQ-007 SHALL have: b_valid  in  1  / b_ready  out  1  multicycle-unit write handshake.
REQ-008 SHALL have: b_addr  in  5  / b_data  in  32  multicycle-unit destination and value.
REQ-009 SHALL have: RegWrite  out  1  / Wt_addr  out  5  / Wt_data  out  32  registered register-file write port.
REQ-010 SHALL have: stall_req  out  1  request for the pipeline to insert a writeback bubble.
REQ-011 SHALL have: fifo_count  out  3  current queue occupancy.

Function
REQ-012 SHALL accept a B transfer on a rising edge where b_valid and b_ready are both 1.
REQ-013 SHALL drive b_ready = (fifo_count < DEPTH) from state only; no combinational path from any input.
REQ-014 SHALL discard accepted B transfers with b_addr = 0 without enqueueing them; SHALL treat a_valid with a_addr = 0 as no request.
REQ-015 SHALL arbitrate at fixed priority each cycle: live A request wins; otherwise a live queue head is popped and written.
REQ-016 SHALL register the winner onto RegWrite/Wt_addr/Wt_data with 1-cycle latency; with no winner, RegWrite = 0 and Wt_addr/Wt_data hold their previous values.
REQ-017 SHALL keep a kill bit per queue entry. On every accepted A write, SHALL set it on every entry already queued with the same address (WAW: the A value is newer).
REQ-018 SHALL keep an entry pushed in the same cycle as a matching A write (B is newer).
REQ-019 SHALL pop a killed head in the cycle it reaches the head, regardless of A, with no port write; this pop SHALL NOT count as a grant.
REQ-020 SHALL allow push and pop in the same cycle, leaving fifo_count unchanged; the queue SHALL wrap modulo DEPTH and keep FIFO order.
REQ-021 SHALL increment a starvation counter, saturating at STARVE_LIMIT, each cycle a live head loses to A; SHALL clear it when the head is popped or the queue is empty.
REQ-022 SHALL drive stall_req = (counter == STARVE_LIMIT) from state; A still wins if asserted while stall_req = 1.

Reset
REQ-023 SHALL, while rst = 1, force queue empty, all kill bits 0, counter 0, RegWrite 0, Wt_addr 0, Wt_data 0, stall_req 0, fifo_count 0, b_ready 0.
REQ-024 SHALL drop pending entries when reset is asserted mid-operation, with no write to the register file; after rst falls, b_ready SHALL be 1 from the first clock edge.

Structure
REQ-025 SHALL place DEPTH/STARVE_LIMIT defaults and the queue entry type (addr 5, data 32, kill 1) in shared package regfile_arb_pkg.
REQ-026 SHALL implement the queue as sub-module regfile_wr_fifo (push, pop, address-match kill port, head outputs, count); arbitration and starvation logic stay in the top.

Verification
REQ-027 SHALL cover A-only: a_valid, a_addr 5, a_data 0x11 -> next cycle RegWrite 1, Wt_addr 5, Wt_data 0x11.
REQ-028 SHALL cover conflict: A (3, 0xAA) and B (7, 0xBB) in the same cycle -> A written next cycle, B written the cycle after, fifo_count 1 then 0.
REQ-029 SHALL cover WAW kill: B (9, 0x1) queued behind a live A stream, then A (9, 0x2) -> only 0x2 is written to x9, and the killed entry is popped silently.
REQ-030 SHALL cover full and x0: 4 B pushes while A is continuous -> b_ready 0, fifo_count 4; a B push to address 0 -> no enqueue and no write.
REQ-031 SHALL cover starvation: queued B with A held for 8 cycles -> stall_req 1 on the 9th cycle; one A bubble -> B written, stall_req 0.
REQ-032 SHALL cover reset mid-operation: 3 entries queued, then rst pulse -> fifo_count 0, RegWrite 0, and no stale writes afterwards.

Source files
------------

// File: rtl/regfile_arb_pkg.sv
// Shared types and defaults for the register-file write arbiter.
// Queue entries carry a kill bit so superseded B writes drop silently.
package regfile_arb_pkg;
   localparam int DEPTH_DEF  = 4;
   localparam int STARVE_DEF = 8;
   localparam int CNT_W      = 3;

   typedef struct packed {
      logic [4:0]  addr;
      logic [31:0] data;
      logic        kill;
   } wr_entry_t;
endpackage

// File: rtl/regfile_wr_fifo.sv
// Pending B-side write queue with per-entry kill by address match.
// A push always lands with kill clear: the pushed value is the newest.
module regfile_wr_fifo
   import regfile_arb_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [4:0]       push_addr,
   input  logic [31:0]      push_data,
   input  logic             pop,
   input  logic             kill_en,
   input  logic [4:0]       kill_addr,
   output logic [4:0]       head_addr,
   output logic [31:0]      head_data,
   output logic             head_kill,
   output logic [CNT_W-1:0] count
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   wr_entry_t      mem [DEPTH];
   logic [PW-1:0]  wr_ptr;
   logic [PW-1:0]  rd_ptr;

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign head_addr = mem[rd_ptr].addr;
   assign head_data = mem[rd_ptr].data;
   assign head_kill = mem[rd_ptr].kill;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++)
            if (kill_en && mem[i].addr == kill_addr)
               mem[i].kill <= 1'b1;
         // later assignment overrides a kill on the slot being written
         if (push) begin
            mem[wr_ptr] <= '{addr: push_addr, data: push_data, kill: 1'b0};
            wr_ptr      <= nxt(wr_ptr);
         end
         if (pop)
            rd_ptr <= nxt(rd_ptr);
         if (push && !pop)
            count <= count + 1'b1;
         else if (pop && !push)
            count <= count - 1'b1;
      end
   end
endmodule

// File: rtl/regfile_wr_arbiter.sv
// Merges pipeline writeback (A) with queued multicycle writes (B)
// onto one registered register-file write port; A has priority.
module regfile_wr_arbiter
   import regfile_arb_pkg::*;
#(
   parameter int DEPTH        = DEPTH_DEF,
   parameter int STARVE_LIMIT = STARVE_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        a_valid,
   input  logic [4:0]  a_addr,
   input  logic [31:0] a_data,
   input  logic        b_valid,
   output logic        b_ready,
   input  logic [4:0]  b_addr,
   input  logic [31:0] b_data,
   output logic        RegWrite,
   output logic [4:0]  Wt_addr,
   output logic [31:0] Wt_data,
   output logic        stall_req,
   output logic [2:0]  fifo_count
);
   localparam int SW = $clog2(STARVE_LIMIT + 1);

   logic          up_q;
   logic [SW-1:0] starve_q;
   logic          a_live;
   logic          push;
   logic          pop;
   logic          head_vld;
   logic          head_live;
   logic          grant_b;
   logic [4:0]    head_addr;
   logic [31:0]   head_data;
   logic          head_kill;

   assign a_live    = a_valid && a_addr != 5'd0;
   assign push      = b_valid && b_ready && b_addr != 5'd0;
   assign head_vld  = fifo_count != '0;
   assign head_live = head_vld && !head_kill;
   assign grant_b   = head_live && !a_live;
   assign pop       = head_vld && (head_kill || !a_live);

   // up_q keeps b_ready low through reset without a path from rst
   assign b_ready   = up_q && (fifo_count < CNT_W'(DEPTH));
   assign stall_req = starve_q == SW'(STARVE_LIMIT);

   regfile_wr_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_addr (b_addr),
      .push_data (b_data),
      .pop       (pop),
      .kill_en   (a_live),
      .kill_addr (a_addr),
      .head_addr (head_addr),
      .head_data (head_data),
      .head_kill (head_kill),
      .count     (fifo_count)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         up_q     <= 1'b0;
         starve_q <= '0;
         RegWrite <= 1'b0;
         Wt_addr  <= '0;
         Wt_data  <= '0;
      end else begin
         up_q <= 1'b1;
         if (head_live && a_live) begin
            if (!stall_req)
               starve_q <= starve_q + 1'b1;
         end else begin
            starve_q <= '0;
         end
         unique case (1'b1)
            a_live: begin
               RegWrite <= 1'b1;
               Wt_addr  <= a_addr;
               Wt_data  <= a_data;
            end
            grant_b: begin
               RegWrite <= 1'b1;
               Wt_addr  <= head_addr;
               Wt_data  <= head_data;
            end
            default: RegWrite <= 1'b0;
         endcase
      end
   end
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter with a write scoreboard.
// Expected port writes are queued in order and matched at negedge.
module tb_regfile_wr_arbiter;
   logic        clk = 1'b0;
   logic        rst;
   logic        a_valid;
   logic [4:0]  a_addr;
   logic [31:0] a_data;
   logic        b_valid;
   logic        b_ready;
   logic [4:0]  b_addr;
   logic [31:0] b_data;
   logic        RegWrite;
   logic [4:0]  Wt_addr;
   logic [31:0] Wt_data;
   logic        stall_req;
   logic [2:0]  fifo_count;

   int n_chk  = 0;
   int n_pass = 0;
   logic [36:0] sb [$];

   regfile_wr_arbiter dut (
      .clk        (clk),
      .rst        (rst),
      .a_valid    (a_valid),
      .a_addr     (a_addr),
      .a_data     (a_data),
      .b_valid    (b_valid),
      .b_ready    (b_ready),
      .b_addr     (b_addr),
      .b_data     (b_data),
      .RegWrite   (RegWrite),
      .Wt_addr    (Wt_addr),
      .Wt_data    (Wt_data),
      .stall_req  (stall_req),
      .fifo_count (fifo_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   always @(negedge clk) begin
      if (RegWrite === 1'b1) begin
         chk("sb_expect_wr", 64'(sb.size() > 0), 64'd1);
         if (sb.size() > 0) begin
            logic [36:0] e;
            e = sb.pop_front();
            chk("sb_addr", 64'(Wt_addr), 64'(e[36:32]));
            chk("sb_data", 64'(Wt_data), 64'(e[31:0]));
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      a_valid = 1'b0;
      b_valid = 1'b0;
      a_addr  = '0;
      a_data  = '0;
      b_addr  = '0;
      b_data  = '0;
   endtask

   task automatic drv_a(input logic [4:0] ad, input logic [31:0] d);
      a_valid = 1'b1;
      a_addr  = ad;
      a_data  = d;
      sb.push_back({ad, d});
   endtask

   task automatic drv_b(input logic [4:0] ad, input logic [31:0] d);
      b_valid = 1'b1;
      b_addr  = ad;
      b_data  = d;
   endtask

   initial begin
      rst = 1'b1;
      idle();
      cyc();
      cyc();
      chk("rst_regwrite", 64'(RegWrite), 64'd0);
      chk("rst_wt_addr", 64'(Wt_addr), 64'd0);
      chk("rst_wt_data", 64'(Wt_data), 64'd0);
      chk("rst_stall", 64'(stall_req), 64'd0);
      chk("rst_count", 64'(fifo_count), 64'd0);
      chk("rst_b_ready", 64'(b_ready), 64'd0);
      rst = 1'b0;
      cyc();
      chk("post_rst_b_ready", 64'(b_ready), 64'd1);

      // A only
      drv_a(5'd5, 32'h11);
      cyc();
      chk("a_only_we", 64'(RegWrite), 64'd1);
      chk("a_only_addr", 64'(Wt_addr), 64'd5);
      chk("a_only_data", 64'(Wt_data), 64'h11);
      idle();
      cyc();
      chk("idle_we", 64'(RegWrite), 64'd0);
      chk("idle_hold_addr", 64'(Wt_addr), 64'd5);
      chk("idle_hold_data", 64'(Wt_data), 64'h11);

      // A and B conflict
      drv_a(5'd3, 32'hAA);
      drv_b(5'd7, 32'hBB);
      cyc();
      chk("cf_a_addr", 64'(Wt_addr), 64'd3);
      chk("cf_count1", 64'(fifo_count), 64'd1);
      idle();
      sb.push_back({5'd7, 32'hBB});
      cyc();
      chk("cf_b_we", 64'(RegWrite), 64'd1);
      chk("cf_b_addr", 64'(Wt_addr), 64'd7);
      chk("cf_b_data", 64'(Wt_data), 64'hBB);
      chk("cf_count0", 64'(fifo_count), 64'd0);

      // WAW kill
      drv_a(5'd1, 32'h100);
      drv_b(5'd9, 32'h1);
      cyc();
      chk("waw_count_a", 64'(fifo_count), 64'd1);
      idle();
      drv_a(5'd2, 32'h101);
      cyc();
      chk("waw_count_b", 64'(fifo_count), 64'd1);
      drv_a(5'd9, 32'h2);
      cyc();
      chk("waw_a_data", 64'(Wt_data), 64'h2);
      idle();
      cyc();
      chk("waw_silent_we", 64'(RegWrite), 64'd0);
      chk("waw_count0", 64'(fifo_count), 64'd0);

      // fill the queue behind continuous A
      for (int i = 0; i < 4; i++) begin
         drv_a(5'(20 + i), 32'hA0 + 32'(i));
         drv_b(5'(12 + i), 32'hB0 + 32'(i));
         cyc();
      end
      chk("full_count", 64'(fifo_count), 64'd4);
      chk("full_b_ready", 64'(b_ready), 64'd0);
      drv_a(5'd24, 32'hA4);
      drv_b(5'd30, 32'hBAD);
      cyc();
      chk("full_reject", 64'(fifo_count), 64'd4);
      idle();
      for (int i = 0; i < 4; i++) begin
         sb.push_back({5'(12 + i), 32'hB0 + 32'(i)});
         cyc();
         chk("drain_addr", 64'(Wt_addr), 64'(12 + i));
         chk("drain_count", 64'(fifo_count), 64'(3 - i));
      end

      // x0 writes are dropped on both sides
      drv_b(5'd0, 32'hDEAD);
      cyc();
      chk("x0_b_count", 64'(fifo_count), 64'd0);
      idle();
      cyc();
      chk("x0_b_we", 64'(RegWrite), 64'd0);
      a_valid = 1'b1;
      a_addr  = 5'd0;
      a_data  = 32'h77;
      cyc();
      chk("x0_a_we", 64'(RegWrite), 64'd0);
      idle();

      // starvation
      drv_a(5'd1, 32'h50);
      drv_b(5'd16, 32'h5A);
      cyc();
      chk("stv_count", 64'(fifo_count), 64'd1);
      chk("stv_start", 64'(stall_req), 64'd0);
      idle();
      for (int k = 1; k <= 9; k++) begin
         drv_a(5'd2, 32'h60 + 32'(k));
         cyc();
         chk("stv_stall", 64'(stall_req), 64'(k >= 8));
      end
      chk("stv_a_wins", 64'(Wt_addr), 64'd2);
      idle();
      sb.push_back({5'd16, 32'h5A});
      cyc();
      chk("stv_b_addr", 64'(Wt_addr), 64'd16);
      chk("stv_clear", 64'(stall_req), 64'd0);
      chk("stv_count0", 64'(fifo_count), 64'd0);

      // reset with entries pending
      for (int i = 0; i < 3; i++) begin
         drv_a(5'(21 + i), 32'hC0 + 32'(i));
         drv_b(5'(17 + i), 32'hD0 + 32'(i));
         cyc();
      end
      chk("mid_count3", 64'(fifo_count), 64'd3);
      idle();
      @(negedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("mid_rst_count", 64'(fifo_count), 64'd0);
      chk("mid_rst_we", 64'(RegWrite), 64'd0);
      chk("mid_rst_b_ready", 64'(b_ready), 64'd0);
      cyc();
      rst = 1'b0;
      cyc();
      chk("mid_b_ready", 64'(b_ready), 64'd1);
      for (int i = 0; i < 4; i++) begin
         cyc();
         chk("mid_no_stale", 64'(RegWrite), 64'd0);
      end
      chk("mid_count0", 64'(fifo_count), 64'd0);

      for (int i = 0; i < 20 && sb.size() > 0; i++) cyc();
      chk("sb_drained", 64'(sb.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
